cla_seq_ctrl: RTL and testbench

CLA_SEQ_CTRL -- requirements
Module: cla_seq_ctrl

---
 rtl/cla_pkg.sv | 18 +
 rtl/cla8.sv | 45 ++++
 rtl/cla_seq_ctrl.sv | 146 ++++++++++++++
 tb/tb_cla_seq_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the limb-serial carry-lookahead adder controller.
package cla_pkg;

  localparam int LIMB_W     = 8;
  localparam int NBYTES_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index register width; a single-limb index still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cla8.sv
// 8-bit carry-lookahead adder with carry-in; every carry is a flat
// generate/propagate sum of products rather than a ripple chain.
module cla8
  import cla_pkg::*;
(
  input  logic [LIMB_W-1:0] a,
  input  logic [LIMB_W-1:0] b,
  input  logic              cin,
  output logic [LIMB_W-1:0] sum,
  output logic              cout
);

  logic [LIMB_W-1:0] g_s;
  logic [LIMB_W-1:0] p_s;
  logic [LIMB_W:0]   c_s;

  // Generate, propagate and the lookahead carries.
  always_comb begin : lookahead
    logic term;
    logic acc;
    g_s    = a & b;
    p_s    = a ^ b;
    c_s    = '0;
    c_s[0] = cin;
    for (int i = 0; i < LIMB_W; i++) begin
      term = cin;
      for (int j = 0; j <= i; j++) begin
        term = term & p_s[j];
      end
      acc = term;
      for (int k = 0; k <= i; k++) begin
        term = g_s[k];
        for (int j = k + 1; j <= i; j++) begin
          term = term & p_s[j];
        end
        acc = acc | term;
      end
      c_s[i+1] = acc;
    end
  end

  assign sum  = p_s ^ c_s[LIMB_W-1:0];
  assign cout = c_s[LIMB_W];

endmodule

// File: rtl/cla_seq_ctrl.sv
// Limb-serial adder/subtractor: one 8-bit lookahead adder is reused for one
// limb per clock, with a valid/ready request side and a held result side.
module cla_seq_ctrl
  import cla_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEF
)
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     op_sub,
  input  logic [LIMB_W*NBYTES-1:0] a,
  input  logic [LIMB_W*NBYTES-1:0] b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LIMB_W*NBYTES-1:0] sum,
  output logic                     cout,
  output logic                     ovf
);

  localparam int W     = LIMB_W * NBYTES;
  localparam int IDX_W = idx_width(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t             state_r;
  state_t             state_nxt;
  logic [IDX_W-1:0]   idx_r;
  logic               carry_r;
  logic [W-1:0]       a_r;
  logic [W-1:0]       b_r;
  logic [W-1:0]       sum_r;
  logic               cout_r;
  logic               ovf_r;

  logic               accept_s;
  logic               step_s;
  logic               last_s;
  logic [LIMB_W-1:0]  limb_a_s;
  logic [LIMB_W-1:0]  limb_b_s;
  logic [LIMB_W-1:0]  limb_sum_s;
  logic               limb_cout_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state and datapath strobes; unknown encodings fall back to IDLE.
  always_comb begin
    state_nxt = IDLE;
    accept_s  = 1'b0;
    step_s    = 1'b0;
    last_s    = (idx_r == LAST_IDX);
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          accept_s  = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        step_s = 1'b1;
        if (last_s) begin
          state_nxt = DONE;
        end else begin
          state_nxt = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = DONE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Select the current limb of both latched operands.
  always_comb begin
    limb_a_s = '0;
    limb_b_s = '0;
    for (int i = 0; i < NBYTES; i++) begin
      limb_a_s = limb_a_s | ({LIMB_W{idx_r == IDX_W'(i)}} & a_r[i*LIMB_W +: LIMB_W]);
      limb_b_s = limb_b_s | ({LIMB_W{idx_r == IDX_W'(i)}} & b_r[i*LIMB_W +: LIMB_W]);
    end
  end

  cla8 u_cla8 (
    .a    (limb_a_s),
    .b    (limb_b_s),
    .cin  (carry_r),
    .sum  (limb_sum_s),
    .cout (limb_cout_s)
  );

  // Operand capture, per-limb result write and final flag capture.
  // Subtraction is a + ~b + 1, so the initial carry is op_sub itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      idx_r   <= '0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (accept_s) begin
      a_r     <= a;
      b_r     <= op_sub ? ~b : b;
      carry_r <= op_sub;
      idx_r   <= '0;
    end else if (step_s) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (idx_r == IDX_W'(i)) begin
          sum_r[i*LIMB_W +: LIMB_W] <= limb_sum_s;
        end
      end
      carry_r <= limb_cout_s;
      if (last_s) begin
        cout_r <= limb_cout_s;
        ovf_r  <= (a_r[W-1] == b_r[W-1]) && (limb_sum_s[LIMB_W-1] != a_r[W-1]);
      end else begin
        idx_r <= idx_r + IDX_W'(1);
      end
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Self-checking bench for cla_seq_ctrl: directed vector table, mid-run reset
// sequence, and randomized traffic against an arithmetic reference model.
module tb_cla_seq_ctrl;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         op_sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic         sub;
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           hold;
  } vec_t;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  vec_t vecs[8];
  exp_t exp_q[$];

  cla_seq_ctrl #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference: plain wide-integer arithmetic on the operands.
  function automatic exp_t model(input logic sub, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t         e;
    logic [63:0]  ur;
    longint       sr;
    longint       sx;
    longint       sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (sub) begin
      ur  = {32'd0, x} - {32'd0, y};
      sr  = sx - sy;
      e.c = (x >= y);
    end else begin
      ur  = {32'd0, x} + {32'd0, y};
      sr  = sx + sy;
      e.c = ur[32];
    end
    e.s = ur[31:0];
    e.o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return e;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check({tag, " in_ready_before"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    op_sub   = v.sub;
    a        = v.va;
    b        = v.vb;
    @(posedge clk); #1;
    check({tag, " busy_after_accept"}, {62'd0, in_ready, out_valid}, 64'd0);
    n = 0;
    while (!out_valid && n < 20) begin
      in_valid = 1'($urandom_range(0, 1));
      op_sub   = 1'($urandom_range(0, 1));
      a        = $urandom;
      b        = $urandom;
      @(posedge clk); #1; n++;
    end
    check({tag, " latency"}, 64'(n), 64'(NB));
    check({tag, " sum"}, 64'(sum), 64'(v.s));
    check({tag, " cout_ovf"}, {62'd0, cout, ovf}, {62'd0, v.c, v.o});
    for (int h = 0; h < v.hold; h++) begin
      out_ready = 1'b0;
      in_valid  = 1'($urandom_range(0, 1));
      a         = $urandom;
      @(posedge clk); #1;
      check({tag, " hold"}, {28'd0, out_valid, in_ready, cout, ovf, sum},
            {28'd0, 1'b1, 1'b0, v.c, v.o, v.s});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " release"}, {28'd0, in_ready, out_valid, cout, ovf, sum},
          {28'd0, 1'b1, 1'b0, v.c, v.o, v.s});
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0, 0};
    vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 0};
    vecs[2] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 0};
    vecs[3] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 2};
    vecs[4] = '{1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 10};
    vecs[5] = '{1'b0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0, 1};
    vecs[6] = '{1'b1, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 0};
    vecs[7] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 3};

    #3;
    check("reset_state", {28'd0, in_ready, out_valid, cout, ovf, sum}, {28'd0, 4'b1000, 32'd0});
    @(posedge clk); #7;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset while the third limb is pending.
    in_valid = 1'b1;
    op_sub   = 1'b0;
    a        = 32'h0102_0304;
    b        = 32'h1010_1010;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midrun_partial", 64'(sum[15:0]), 64'h1314);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_reset", {28'd0, in_ready, out_valid, cout, ovf, sum}, {28'd0, 4'b1000, 32'd0});
    @(posedge clk); #3;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("aborted_no_result", {62'd0, in_ready, out_valid}, 64'd2);
    end
    run_vec('{1'b0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0, 0}, "post_reset");

    // Randomized back-to-back traffic with in_valid held high.
    begin
      logic         pir;
      logic         pov;
      logic         por;
      logic         ps;
      logic [W-1:0] pa;
      logic [W-1:0] pb;
      logic [W-1:0] psum;
      logic         pc;
      logic         po;
      exp_t         e;
      int           lat;
      int           results;
      logic [W-1:0] corner[5];
      corner[0] = 32'h0000_0000;
      corner[1] = 32'hFFFF_FFFF;
      corner[2] = 32'h7FFF_FFFF;
      corner[3] = 32'h8000_0000;
      corner[4] = 32'h0000_0001;
      lat     = 0;
      results = 0;
      in_valid = 1'b1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
        b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
        op_sub    = 1'($urandom_range(0, 1));
        out_ready = ($urandom_range(0, 2) != 0);
        pir = in_ready; pov = out_valid; por = out_ready;
        ps = op_sub; pa = a; pb = b;
        psum = sum; pc = cout; po = ovf;
        @(posedge clk); #1;
        if (pir) begin
          exp_q.push_back(model(ps, pa, pb));
          lat = 0;
          check("rnd_accept_busy", 64'(in_ready), 64'd0);
        end else begin
          lat++;
        end
        if (pov && por) begin
          check("rnd_release_idle", {62'd0, in_ready, out_valid}, 64'd2);
        end else if (pov) begin
          check("rnd_hold", {29'd0, out_valid, cout, ovf, sum}, {29'd0, 1'b1, pc, po, psum});
        end else if (out_valid) begin
          results++;
          check("rnd_latency", 64'(lat), 64'(NB));
          if (exp_q.size() == 0) begin
            check("rnd_unexpected_result", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("rnd_result", {31'd0, cout, ovf, sum}, {31'd0, e.c, e.o, e.s});
          end
        end
      end
      check("rnd_pending", 64'(exp_q.size() <= 1), 64'd1);
      check("rnd_enough_results", 64'(results > 200), 64'd1);
      in_valid  = 1'b0;
      out_ready = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
